// File: rtl/toggle_rx_pkg.sv
// Shared types and default sizes for toggle receivers.
package toggle_rx_pkg;

   localparam int SYNC_STAGES_DEF = 2;
   localparam int DATA_W_DEF      = 8;
   localparam int CNT_W_DEF       = 16;

   typedef enum logic {
      IDLE = 1'b0,
      FULL = 1'b1
   } state_t;

endpackage

// File: rtl/tgl_sync.sv
// Multi-flop synchronizer for a single asynchronous toggle line.
module tgl_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic async_in,
   output logic sync_out
);

   logic [STAGES-1:0] chain;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chain <= '0;
      end else begin
         chain <= {chain[STAGES-2:0], async_in};
      end
   end

   assign sync_out = chain[STAGES-1];

endmodule

// File: rtl/toggle_rx.sv
// Two-phase toggle receiver with valid/ready output and toggle acknowledge.
// Optional saturating event counter enabled by defining TOGGLE_RX_EVCNT_EN.
module toggle_rx
   import toggle_rx_pkg::*;
#(
   parameter int SYNC_STAGES = SYNC_STAGES_DEF,
   parameter int DATA_W      = DATA_W_DEF,
   parameter int CNT_W       = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_t,
   input  logic [DATA_W-1:0] din,
   input  logic              ready,
   input  logic              clr_ovr,
   output logic              ack_t,
   output logic [DATA_W-1:0] dout,
   output logic              valid,
   output logic              ovr,
   output logic [CNT_W-1:0]  evcnt
);

   state_t state_q;
   state_t state_d;
   logic   req_s;
   logic   req_d;
   logic   req_edge;
   logic   capture;
   logic   consume;
   logic   overrun;

   tgl_sync #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .async_in (req_t),
      .sync_out (req_s)
   );

   assign req_edge = req_s ^ req_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // An edge seen while a word is still held is dropped and flagged; the held word may still be consumed.
   always_comb begin
      state_d = state_q;
      capture = 1'b0;
      consume = 1'b0;
      overrun = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_edge) begin
               capture = 1'b1;
               state_d = FULL;
            end
         end
         FULL: begin
            if (ready) begin
               consume = 1'b1;
               state_d = IDLE;
            end
            if (req_edge) begin
               overrun = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign valid = (state_q == FULL);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_d <= 1'b0;
         dout  <= '0;
         ack_t <= 1'b0;
         ovr   <= 1'b0;
      end else begin
         req_d <= req_s;
         if (capture) begin
            dout <= din;
         end
         if (consume) begin
            ack_t <= ~ack_t;
         end
         if (overrun) begin
            ovr <= 1'b1;
         end else if (clr_ovr) begin
            ovr <= 1'b0;
         end
      end
   end

`ifdef TOGGLE_RX_EVCNT_EN
   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (consume && (cnt_q != '1)) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign evcnt = cnt_q;
`else
   assign evcnt = '0;
`endif

endmodule

// File: tb/tb_toggle_rx.sv
// Directed, table-driven bench for toggle_rx (small counter width to reach saturation).
module tb_toggle_rx;

   localparam int CNT_W = 4;

   logic             clk;
   logic             rst_n;
   logic             req_t;
   logic [7:0]       din;
   logic             ready;
   logic             clr_ovr;
   logic             ack_t;
   logic [7:0]       dout;
   logic             valid;
   logic             ovr;
   logic [CNT_W-1:0] evcnt;

   int n_checks;
   int n_fail;
   int exp_cnt;
   logic exp_ack;

   typedef struct {
      logic [7:0] din;
      int         hold;
      logic [7:0] exp_dout;
   } vec_t;

   vec_t vecs [5];

   toggle_rx #(
      .SYNC_STAGES (2),
      .DATA_W      (8),
      .CNT_W       (CNT_W)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req_t   (req_t),
      .din     (din),
      .ready   (ready),
      .clr_ovr (clr_ovr),
      .ack_t   (ack_t),
      .dout    (dout),
      .valid   (valid),
      .ovr     (ovr),
      .evcnt   (evcnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic int nextCnt(input int c);
`ifdef TOGGLE_RX_EVCNT_EN
      return (c == (1 << CNT_W) - 1) ? c : c + 1;
`else
      return 0;
`endif
   endfunction

   // Call #1 after a rising edge: one toggle, check capture latency, hold, then consume.
   task automatic applyStimulus(input logic [7:0] d, input int hold, input logic [7:0] exp_d);
      din   = d;
      req_t = ~req_t;
      ready = (hold == 0);
      tick(2);
      checkOutput("valid_before_capture", 32'(valid), 32'(1'b0));
      tick(1);
      checkOutput("valid_at_capture", 32'(valid), 32'(1'b1));
      checkOutput("dout_at_capture", 32'(dout), 32'(exp_d));
      for (int i = 0; i < hold; i++) begin
         tick(1);
         checkOutput("valid_held", 32'(valid), 32'(1'b1));
         checkOutput("dout_held", 32'(dout), 32'(exp_d));
         checkOutput("ack_held", 32'(ack_t), 32'(exp_ack));
      end
      ready = 1'b1;
      tick(1);
      exp_ack = ~exp_ack;
      exp_cnt = nextCnt(exp_cnt);
      checkOutput("valid_after_consume", 32'(valid), 32'(1'b0));
      checkOutput("ack_after_consume", 32'(ack_t), 32'(exp_ack));
      checkOutput("evcnt_after_consume", 32'(evcnt), 32'(exp_cnt));
      ready = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      exp_cnt  = 0;
      exp_ack  = 1'b0;
      rst_n    = 1'b0;
      req_t    = 1'b0;
      din      = 8'h00;
      ready    = 1'b0;
      clr_ovr  = 1'b0;

      vecs[0] = '{din: 8'hA5, hold: 0,  exp_dout: 8'hA5};
      vecs[1] = '{din: 8'hA5, hold: 10, exp_dout: 8'hA5};
      vecs[2] = '{din: 8'h3C, hold: 2,  exp_dout: 8'h3C};
      vecs[3] = '{din: 8'h00, hold: 1,  exp_dout: 8'h00};
      vecs[4] = '{din: 8'hFF, hold: 0,  exp_dout: 8'hFF};

      tick(3);
      checkOutput("reset_ack", 32'(ack_t), 32'(1'b0));
      checkOutput("reset_valid", 32'(valid), 32'(1'b0));
      checkOutput("reset_dout", 32'(dout), 32'h00);
      checkOutput("reset_ovr", 32'(ovr), 32'(1'b0));
      checkOutput("reset_evcnt", 32'(evcnt), 32'h0);

      @(negedge clk);
      rst_n = 1'b1;
      tick(2);

      for (int v = 0; v < 5; v++) begin
         applyStimulus(vecs[v].din, vecs[v].hold, vecs[v].exp_dout);
         tick(1);
      end

      // Overrun: second toggle while the first word is still held.
      ready = 1'b0;
      din   = 8'h11;
      req_t = ~req_t;
      tick(3);
      checkOutput("ovr_first_valid", 32'(valid), 32'(1'b1));
      checkOutput("ovr_first_dout", 32'(dout), 32'h11);
      din   = 8'h22;
      req_t = ~req_t;
      tick(2);
      checkOutput("ovr_before_second", 32'(ovr), 32'(1'b0));
      tick(1);
      checkOutput("ovr_set", 32'(ovr), 32'(1'b1));
      checkOutput("ovr_dout_kept", 32'(dout), 32'h11);
      checkOutput("ovr_valid_kept", 32'(valid), 32'(1'b1));
      checkOutput("ovr_no_ack", 32'(ack_t), 32'(exp_ack));
      tick(2);
      checkOutput("ovr_sticky", 32'(ovr), 32'(1'b1));
      clr_ovr = 1'b1;
      tick(1);
      clr_ovr = 1'b0;
      checkOutput("ovr_cleared", 32'(ovr), 32'(1'b0));

      din   = 8'h33;
      req_t = ~req_t;
      tick(2);
      clr_ovr = 1'b1;
      tick(1);
      clr_ovr = 1'b0;
      checkOutput("ovr_set_wins", 32'(ovr), 32'(1'b1));
      checkOutput("ovr_dout_kept2", 32'(dout), 32'h11);
      tick(1);
      checkOutput("ovr_sticky2", 32'(ovr), 32'(1'b1));
      clr_ovr = 1'b1;
      tick(1);
      clr_ovr = 1'b0;
      checkOutput("ovr_cleared2", 32'(ovr), 32'(1'b0));

      ready = 1'b1;
      tick(1);
      ready   = 1'b0;
      exp_ack = ~exp_ack;
      exp_cnt = nextCnt(exp_cnt);
      checkOutput("ovr_consume_valid", 32'(valid), 32'(1'b0));
      checkOutput("ovr_consume_ack", 32'(ack_t), 32'(exp_ack));
      checkOutput("ovr_consume_dout", 32'(dout), 32'h11);
      checkOutput("ovr_consume_evcnt", 32'(evcnt), 32'(exp_cnt));
      tick(3);
      checkOutput("ovr_no_extra_valid", 32'(valid), 32'(1'b0));

      // Saturation: 20 more consumed events on a 4-bit counter.
      for (int e = 0; e < 20; e++) begin
         applyStimulus(8'(e * 7 + 1), 0, 8'(e * 7 + 1));
      end
`ifdef TOGGLE_RX_EVCNT_EN
      checkOutput("evcnt_saturated", 32'(evcnt), 32'hF);
`else
      checkOutput("evcnt_tied_zero", 32'(evcnt), 32'h0);
`endif

      // Reset while a word is pending.
      din   = 8'h5A;
      req_t = ~req_t;
      tick(3);
      checkOutput("midrst_valid_pre", 32'(valid), 32'(1'b1));
      #2;
      rst_n = 1'b0;
      req_t = 1'b0;
      #1;
      exp_ack = 1'b0;
      exp_cnt = 0;
      checkOutput("midrst_valid", 32'(valid), 32'(1'b0));
      checkOutput("midrst_dout", 32'(dout), 32'h00);
      checkOutput("midrst_ack", 32'(ack_t), 32'(1'b0));
      checkOutput("midrst_ovr", 32'(ovr), 32'(1'b0));
      checkOutput("midrst_evcnt", 32'(evcnt), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      tick(2);
      checkOutput("postrst_idle", 32'(valid), 32'(1'b0));
      applyStimulus(8'hC3, 0, 8'hC3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/toggle_rx.md
# toggle_rx

Receiving end of the two-phase toggle signalling used by our toggle flip-flop sources. Each transition of an incoming toggle line `req_t` from an unrelated clock or asynchronous domain is one event. The block synchronizes that line into `clk` and captures the accompanying data word. It presents the word on a valid/ready interface and returns a toggle acknowledge `ack_t` to the sender once the consumer has taken the word.

## Interface
- `SYNC_STAGES`, 2, flops in the `req_t` synchronizer chain; minimum 2.
- `DATA_W`, 8, width of `din`/`dout`.
- `CNT_W`, 16, width of the event counter `evcnt`.
- One clock, `clk`; reset is asynchronous and active-low, `rst_n`.
- `clk`  in  1  rising-edge clock for all state.
- `rst_n`  in  1  asynchronous active-low reset.
- `req_t`  in  1  asynchronous request toggle; every transition is one event.
- `din`  in  DATA_W  data from the sender; stable from its `req_t` transition until the matching `ack_t` transition.
- `ready`  in  1  consumer can take `dout`.
- `clr_ovr`  in  1  synchronous clear of `ovr`.
- `ack_t`  out  1  acknowledge toggle; flips once per consumed event.
- `dout`  out  DATA_W  captured data word.
- `valid`  out  1  `dout` holds an unconsumed word.
- `ovr`  out  1  sticky overrun flag.
- `evcnt`  out  CNT_W  count of consumed events, saturating.

## Operation
- **Reset values:** `ack_t`=0, `dout`=0, `valid`=0, `ovr`=0, `evcnt`=0. The synchronizer chain and the previous-sample register `req_d` also reset to 0.
- **Reset convention:** the sender resets its toggle to 0 on the same reset. If `req_t` is 1 at reset release, that counts as one event.
- **Synchronizer:** `req_s` is the last stage of the chain.
- **Edge detect:** `edge = req_s ^ req_d`. `req_d <= req_s` every cycle.
- **State IDLE, on `edge`:** `dout <= din` and `valid <= 1`, then go to FULL.
- **State FULL, on `valid & ready`:** `valid <= 0`, `ack_t <= ~ack_t`, increment `evcnt`, then go to IDLE.
- **State FULL, on `edge`:** this is a protocol violation. Set `ovr <= 1`, drop the event with no ack for it, and leave `dout` unchanged. This applies even when `ready` is high in the same cycle.
- **`clr_ovr`:** clears `ovr`. If an overrun occurs in the same cycle, set wins and `ovr` stays 1.
- **`evcnt`:** saturates at all-ones and never wraps.

## Timing
- **Capture latency:** `req_t` changes before edge 0. `valid` and `dout` update at edge `SYNC_STAGES+1`, which is edge 3 at the default.
- **Data sampling:** `din` is sampled on the same edge that raises `valid`.
- **Consume:** `valid` falls and `ack_t` flips on the edge where `valid & ready` is sampled high. There is no combinational path from `ready` to outputs.
- **Minimum event spacing:** with `ready` held high, round trip per event is `SYNC_STAGES+2` clk cycles of receiver latency.
- **Reset mid-operation:** outputs clear immediately and asynchronously. A pending word is lost without an ack flip, and the sender must also be in reset.

## Configuration
- **`TOGGLE_RX_EVCNT_EN` defined:** the `CNT_W` saturating event counter is built and drives `evcnt`.
- **`TOGGLE_RX_EVCNT_EN` undefined:** no counter logic; the `evcnt` port still exists and is tied to 0. All other behaviour is identical.

## Structure
- **Package `toggle_rx_pkg`:** holds the state enum (IDLE, FULL) and the default parameter values for `SYNC_STAGES`, `DATA_W` and `CNT_W`.
- **Sub-module `tgl_sync`:** the parameterized synchronizer chain with async active-low reset, reused by future toggle receivers.
- **Top level:** edge detect, FSM, capture register, `ovr` and counter stay in `toggle_rx`.

## Test plan
1. **Reset:** `rst_n`=0 with `req_t`=0 → `ack_t`=0, `valid`=0, `dout`=0, `ovr`=0, `evcnt`=0.
2. **Single event:** `din`=8'hA5, `req_t` 0→1, `ready`=1 → `valid`=1 at edge 3 with `dout`=8'hA5 for exactly one cycle. At the next edge `valid`=0, `ack_t`=1 and `evcnt`=1.
3. **Backpressure:** as test 2 but `ready`=0 for 10 cycles → `valid`=1, `dout`=8'hA5 and `ack_t` unchanged throughout. Then `ready`=1 → one accept, `ack_t` flips once.
4. **Overrun:** with `ready`=0, toggle `req_t` twice (`din` 8'h11 then 8'h22) → `ovr`=1 and `dout`=8'h11. A `clr_ovr` pulse then clears `ovr`. With `clr_ovr` coincident with a new overrun, `ovr` stays 1.
5. **Saturation:** `CNT_W`=4, 20 consumed events → `evcnt`=4'hF. Build without `TOGGLE_RX_EVCNT_EN` → `evcnt`=0 throughout.
6. **Reset mid-operation:** drop `rst_n` while `valid`=1 → all outputs 0 within the same time step, no `ack_t` flip. After release a fresh event is captured normally.
